// File: rtl/axis_stereo_gain.sv
// Stereo volume stage: takes L/R sample pairs, scales by a ramped gain, saturates, re-emits L/R.
// Latency: 2 cycles from right-word acceptance to m_axis_valid (CALC, then TX_L).
// Backpressure: output holds stable while m_axis_ready=0; s_axis_ready low outside the two RX states.
//
// Ports:
//   axis_clk, axis_resetn        clock, synchronous active-low reset
//   gain_target                  requested gain, unsigned, unity = 2**(GAIN_W-2)
//   s_axis_data/valid/ready/last input stream, left word then right word (last=1)
//   m_axis_data/valid/ready/last output stream, same packet shape
//   gain_applied                 gain currently in use (status)
module axis_stereo_gain #(
  parameter int GAIN_W    = 16,
  parameter int RAMP_STEP = 64,
  parameter int GAIN_INIT = 2**(GAIN_W-2)
) (
  input  logic              axis_clk,
  input  logic              axis_resetn,
  input  logic [GAIN_W-1:0] gain_target,
  input  logic [23:0]       s_axis_data,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  input  logic              s_axis_last,
  output logic [23:0]       m_axis_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  output logic              m_axis_last,
  output logic [GAIN_W-1:0] gain_applied
);

  // Product width: 24-bit signed sample times (GAIN_W+1)-bit non-negative gain.
  localparam int PW = 24 + GAIN_W + 1;

  localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);
  localparam logic [GAIN_W-1:0] INIT = GAIN_W'(GAIN_INIT);

  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-23){1'b0}}, {23{1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-23){1'b1}}, {23{1'b0}}};

  typedef enum logic [2:0] {
    RX_L = 3'd0,
    RX_R = 3'd1,
    CALC = 3'd2,
    TX_L = 3'd3,
    TX_R = 3'd4
  } state_t;

  state_t      state;
  logic [23:0] samp_l;
  logic [23:0] samp_r;
  logic [23:0] res_r;

  // Signed multiply, arithmetic shift (floors toward -inf), clamp to 24-bit range.
  function automatic logic [23:0] scale(input logic [23:0] s, input logic [GAIN_W-1:0] g);
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] y;
    a = {{(PW-24){s[23]}}, s};
    b = {{(PW-GAIN_W){1'b0}}, g};
    p = a * b;
    y = p >>> (GAIN_W-2);
    if (y > SAT_MAX)
      scale = 24'h7FFFFF;
    else if (y < SAT_MIN)
      scale = 24'h800000;
    else
      scale = y[23:0];
  endfunction

  // Move at most STEP toward the target; snap onto it once within one step.
  function automatic logic [GAIN_W-1:0] step_gain(input logic [GAIN_W-1:0] cur,
                                                  input logic [GAIN_W-1:0] tgt);
    if (tgt >= cur)
      step_gain = ((tgt - cur) <= STEP) ? tgt : (cur + STEP);
    else
      step_gain = ((cur - tgt) <= STEP) ? tgt : (cur - STEP);
  endfunction

  // s_axis_ready is a register that tracks "next state is RX_L/RX_R", so it has
  // no combinational dependence on either stream's inputs.
  always_ff @(posedge axis_clk) begin
    if (!axis_resetn) begin
      state        <= RX_L;
      s_axis_ready <= 1'b0;
      m_axis_valid <= 1'b0;
      m_axis_last  <= 1'b0;
      m_axis_data  <= '0;
      gain_applied <= INIT;
      samp_l       <= '0;
      samp_r       <= '0;
      res_r        <= '0;
    end else begin
      case (state)
        RX_L: begin
          s_axis_ready <= 1'b1;
          // A lone right word here means we lost sync; drop it and keep waiting for a left.
          if (s_axis_valid && s_axis_ready && !s_axis_last) begin
            samp_l <= s_axis_data;
            state  <= RX_R;
          end
        end
        RX_R: begin
          s_axis_ready <= 1'b1;
          if (s_axis_valid && s_axis_ready) begin
            if (s_axis_last) begin
              samp_r       <= s_axis_data;
              s_axis_ready <= 1'b0;
              state        <= CALC;
            end else begin
              // Missing right word: newest left word replaces the stale one.
              samp_l <= s_axis_data;
            end
          end
        end
        CALC: begin
          // Both products use the gain from before this edge's ramp step.
          m_axis_data  <= scale(samp_l, gain_applied);
          res_r        <= scale(samp_r, gain_applied);
          m_axis_valid <= 1'b1;
          m_axis_last  <= 1'b0;
          gain_applied <= step_gain(gain_applied, gain_target);
          state        <= TX_L;
        end
        TX_L: begin
          if (m_axis_ready) begin
            m_axis_data <= res_r;
            m_axis_last <= 1'b1;
            state       <= TX_R;
          end
        end
        TX_R: begin
          if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            s_axis_ready <= 1'b1;
            state        <= RX_L;
          end
        end
        default: begin
          state        <= RX_L;
          s_axis_ready <= 1'b0;
          m_axis_valid <= 1'b0;
          m_axis_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stereo_gain.sv
// Bench for axis_stereo_gain: scoreboard of expected output words, driven packet by packet.
// Latency: checks the 2-cycle right-word-to-valid latency and ramp timing directly.
// Backpressure: stalls the output for 100 cycles and checks hold-stability, then resets mid-stall.
module tb_axis_stereo_gain;

  logic        axis_clk = 1'b0;
  logic        axis_resetn = 1'b0;
  logic [15:0] gain_target = 16'd16384;
  logic [23:0] s_axis_data = '0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_ready;
  logic        s_axis_last = 1'b0;
  logic [23:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready = 1'b1;
  logic        m_axis_last;
  logic [15:0] gain_applied;

  axis_stereo_gain dut (
    .axis_clk     (axis_clk),
    .axis_resetn  (axis_resetn),
    .gain_target  (gain_target),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_last  (s_axis_last),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .gain_applied (gain_applied)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [23:0] dat;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   pkts_out = 0;
  int   exp_pkts = 0;
  int   g_model = 16384;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    else
      n_pass++;
  endtask

  // Reference arithmetic: 64-bit product, floor shift by 14, clamp to 24 bits.
  function automatic logic [23:0] ref_scale(input logic [23:0] s, input int g);
    longint p;
    logic [63:0] pv;
    p = longint'($signed(s)) * longint'(g);
    p = p >>> 14;
    if (p > 64'sd8388607)  p = 64'sd8388607;
    if (p < -64'sd8388608) p = -64'sd8388608;
    pv = p;
    return pv[23:0];
  endfunction

  function automatic int ref_step(input int g, input int t);
    if (t >= g) return (t - g <= 64) ? t : g + 64;
    else        return (g - t <= 64) ? t : g - 64;
  endfunction

  // Output monitor: sampled on the falling edge, mid-cycle.
  logic        stall_prev = 1'b0;
  logic [23:0] prev_dat = '0;
  logic        prev_last = 1'b0;
  always @(negedge axis_clk) begin
    exp_t e;
    if (axis_resetn && stall_prev) begin
      chk("hold_valid", m_axis_valid, 1'b1);
      chk("hold_data", m_axis_data, prev_dat);
      chk("hold_last", m_axis_last, prev_last);
    end
    stall_prev = axis_resetn && m_axis_valid && !m_axis_ready;
    prev_dat   = m_axis_data;
    prev_last  = m_axis_last;
    if (axis_resetn && m_axis_valid && m_axis_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", m_axis_data, e.dat);
        chk("out_last", m_axis_last, e.last);
      end
      if (m_axis_last) pkts_out++;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_word(input logic [23:0] d, input logic l);
    int t = 0;
    s_axis_data  = d;
    s_axis_last  = l;
    s_axis_valid = 1'b1;
    @(negedge axis_clk);
    while (!s_axis_ready && t < 200) begin
      @(negedge axis_clk);
      t++;
    end
    if (!s_axis_ready) chk("s_ready_timeout", s_axis_ready, 1'b1);
    @(posedge axis_clk);
    #1;
    s_axis_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int n);
    int t = 0;
    while (pkts_out < n && t < 300) begin
      @(posedge axis_clk);
      #1;
      t++;
    end
    if (pkts_out < n) chk("pkt_timeout", 32'(pkts_out), 32'(n));
  endtask

  task automatic push_pkt(input logic [23:0] el, input logic [23:0] er);
    exp_q.push_back('{dat: el, last: 1'b0});
    exp_q.push_back('{dat: er, last: 1'b1});
    g_model = ref_step(g_model, int'(gain_target));
    exp_pkts++;
  endtask

  task automatic send_pkt(input logic [23:0] l, input logic [23:0] r,
                          input bit directed, input logic [23:0] el, input logic [23:0] er);
    if (directed) push_pkt(el, er);
    else          push_pkt(ref_scale(l, g_model), ref_scale(r, g_model));
    send_word(l, 1'b0);
    send_word(r, 1'b1);
    wait_pkts(exp_pkts);
    chk("gain_model", gain_applied, g_model);
  endtask

  task automatic ramp_to(input logic [15:0] t);
    gain_target = t;
    while (g_model != int'(t))
      send_pkt(24'($urandom), 24'($urandom), 1'b0, 24'h0, 24'h0);
  endtask

  int t4_exp[5] = '{16448, 16512, 16576, 16584, 16584};

  initial begin
    // Reset state
    repeat (3) @(posedge axis_clk);
    #1;
    chk("rst_s_ready", s_axis_ready, 1'b0);
    chk("rst_m_valid", m_axis_valid, 1'b0);
    chk("rst_m_last", m_axis_last, 1'b0);
    chk("rst_m_data", m_axis_data, 24'h0);
    chk("rst_gain", gain_applied, 16'd16384);
    axis_resetn = 1'b1;
    @(posedge axis_clk);
    #1;
    chk("post_rst_s_ready", s_axis_ready, 1'b1);

    // T1 unity gain with latency check
    push_pkt(24'h123456, 24'hFEDCBA);
    send_word(24'h123456, 1'b0);
    send_word(24'hFEDCBA, 1'b1);
    chk("lat_calc_valid", m_axis_valid, 1'b0);
    @(posedge axis_clk);
    #1;
    chk("lat_txl_valid", m_axis_valid, 1'b1);
    wait_pkts(exp_pkts);
    chk("t1_gain", gain_applied, 16'd16384);

    // T2 half gain, ramped down
    ramp_to(16'd8192);
    send_pkt(24'h000100, 24'hFFFFFF, 1'b1, 24'h000080, 24'hFFFFFF);
    chk("t2_gain", gain_applied, 16'd8192);

    // T3 saturation at 2x
    ramp_to(16'd32768);
    send_pkt(24'h600000, 24'h900000, 1'b1, 24'h7FFFFF, 24'h800000);

    // T4 ramp granularity from unity
    ramp_to(16'd16384);
    gain_target = 16'd16584;
    for (int i = 0; i < 5; i++) begin
      send_pkt(24'($urandom), 24'($urandom), 1'b0, 24'h0, 24'h0);
      chk("t4_gain", gain_applied, 16'(t4_exp[i]));
    end

    // T5 resync: stray right word, then a left word superseded by another
    push_pkt(ref_scale(24'h222222, g_model), ref_scale(24'h333333, g_model));
    send_word(24'hAAAAAA, 1'b1);
    chk("t5_rdy_after_stray", s_axis_ready, 1'b1);
    send_word(24'h111111, 1'b0);
    chk("t5_rdy_after_l", s_axis_ready, 1'b1);
    send_word(24'h222222, 1'b0);
    chk("t5_rdy_after_l2", s_axis_ready, 1'b1);
    send_word(24'h333333, 1'b1);
    wait_pkts(exp_pkts);
    chk("t5_pkts", 32'(pkts_out), 32'(exp_pkts));

    // T6 backpressure then reset mid-stall
    gain_target  = 16'd16384;
    m_axis_ready = 1'b0;
    push_pkt(ref_scale(24'h010203, g_model), ref_scale(24'h840506, g_model));
    send_word(24'h010203, 1'b0);
    send_word(24'h840506, 1'b1);
    repeat (100) @(posedge axis_clk);
    #1;
    chk("t6_valid_held", m_axis_valid, 1'b1);
    chk("t6_last_held", m_axis_last, 1'b0);
    chk("t6_s_ready", s_axis_ready, 1'b0);
    axis_resetn = 1'b0;
    @(posedge axis_clk);
    #1;
    chk("t6_rst_valid", m_axis_valid, 1'b0);
    chk("t6_rst_s_ready", s_axis_ready, 1'b0);
    chk("t6_rst_gain", gain_applied, 16'd16384);
    axis_resetn  = 1'b1;
    exp_q.delete();
    exp_pkts     = pkts_out;
    g_model      = 16384;
    m_axis_ready = 1'b1;
    @(posedge axis_clk);
    #1;
    chk("t6_rel_s_ready", s_axis_ready, 1'b1);
    chk("t6_rel_valid", m_axis_valid, 1'b0);

    // Recovery packet after reset
    send_pkt(24'h123456, 24'hFEDCBA, 1'b1, 24'h123456, 24'hFEDCBA);
    repeat (5) @(posedge axis_clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
